// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller for a pipelined core.
// It sequences the pipeline reset and gates the pipeline clock enable for
// continuous, single-step and run-N execution. It counts enabled cycles and
// stops on abort, halt, an exhausted budget or a timeout.
module cpu_run_ctrl #(
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       i_mode,
    input  logic             i_start,
    input  logic             i_step,
    input  logic [CNT_W-1:0] i_run_cycles,
    input  logic             i_halt,
    input  logic             i_abort,
    input  logic             i_clear,
    output logic             o_core_rst,
    output logic             o_core_en,
    output logic [CNT_W-1:0] o_cycle_count,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timeout
);

    localparam logic [2:0] RST_SEQ   = 3'd0;
    localparam logic [2:0] IDLE      = 3'd1;
    localparam logic [2:0] RUN       = 3'd2;
    localparam logic [2:0] STEP_WAIT = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    localparam logic [1:0] MODE_CONT = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_RUNN = 2'b10;

    localparam logic [7:0]       RST_LAST    = 8'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);
    localparam bit               TIMEOUT_EN  = (TIMEOUT != 0);

    logic [2:0]       state;
    logic [2:0]       stateNext;
    logic [7:0]       rstCnt;
    logic [CNT_W-1:0] cycleCount;
    logic [CNT_W-1:0] countNext;
    logic [CNT_W-1:0] budget;
    logic             runN;
    logic             stepPrev;
    logic             stepPulse;
    logic             stepEdge;
    logic             timeoutFlag;
    logic             coreEn;
    logic             budgetHit;
    logic             timeoutHit;
    logic             stopByTimeout;
    logic             acceptStart;

    // The enable is a pure decode of registered state so it drops the instant the state changes.
    assign coreEn = (state == RUN) || ((state == STEP_WAIT) && stepPulse);

    // Saturating next count; the budget and timeout compare against the count this cycle will produce.
    assign countNext  = (cycleCount == CNT_MAX) ? cycleCount : cycleCount + 1'b1;
    assign budgetHit  = runN && (countNext == budget);
    assign timeoutHit = TIMEOUT_EN && (countNext == TIMEOUT_VAL);
    assign stepEdge   = i_step && !stepPrev;

    // A start is only taken for the three defined modes and loses to a simultaneous abort.
    assign acceptStart = (state == IDLE) && i_start && !i_abort && (i_mode != 2'b11);

    // Next-state selection; stop causes are ordered abort, halt, budget, timeout.
    always_comb begin
        stateNext     = state;
        stopByTimeout = 1'b0;
        case (state)
            RST_SEQ: begin
                if (rstCnt == RST_LAST) begin
                    stateNext = IDLE;
                end
            end
            IDLE: begin
                if (i_abort) begin
                    stateNext = DONE;
                end else if (i_start) begin
                    case (i_mode)
                        MODE_CONT: stateNext = RUN;
                        MODE_STEP: stateNext = STEP_WAIT;
                        MODE_RUNN: stateNext = (i_run_cycles == '0) ? DONE : RUN;
                        default:   stateNext = IDLE;
                    endcase
                end
            end
            RUN: begin
                if (i_abort || i_halt || budgetHit) begin
                    stateNext = DONE;
                end else if (timeoutHit) begin
                    stateNext     = DONE;
                    stopByTimeout = 1'b1;
                end
            end
            STEP_WAIT: begin
                if (i_abort || (stepPulse && i_halt)) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (i_clear) begin
                    stateNext = RST_SEQ;
                end
            end
            default: stateNext = RST_SEQ;
        endcase
    end

    // State register plus the reset-sequence length counter, which restarts on every entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= RST_SEQ;
            rstCnt <= 8'd0;
        end else begin
            state <= stateNext;
            if ((state == RST_SEQ) && (stateNext == RST_SEQ)) begin
                rstCnt <= rstCnt + 8'd1;
            end else begin
                rstCnt <= 8'd0;
            end
        end
    end

    // Cycle counter, run budget, step edge detector/pulse and sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycleCount  <= '0;
            budget      <= '0;
            runN        <= 1'b0;
            stepPrev    <= 1'b0;
            stepPulse   <= 1'b0;
            timeoutFlag <= 1'b0;
        end else if ((state == DONE) && i_clear) begin
            cycleCount  <= '0;
            budget      <= '0;
            runN        <= 1'b0;
            stepPrev    <= 1'b0;
            stepPulse   <= 1'b0;
            timeoutFlag <= 1'b0;
        end else begin
            if (coreEn) begin
                cycleCount <= countNext;
            end
            stepPrev <= i_step;
            // An edge seen while a pulse is already running is discarded.
            stepPulse <= (state == STEP_WAIT) && (stateNext == STEP_WAIT) &&
                         stepEdge && !stepPulse;
            if (acceptStart) begin
                budget <= i_run_cycles;
                runN   <= (i_mode == MODE_RUNN);
            end
            if ((state != DONE) && (stateNext == DONE)) begin
                timeoutFlag <= stopByTimeout;
            end
        end
    end

    assign o_core_rst    = (state == RST_SEQ);
    assign o_core_en     = coreEn;
    assign o_cycle_count = cycleCount;
    assign o_busy        = (state == RUN) || (state == STEP_WAIT);
    assign o_done        = (state == DONE);
    assign o_timeout     = timeoutFlag;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: randomized self-checking bench for cpu_run_ctrl.
// Expected results come from a scenario-level model: a run stops at the
// earliest of abort, halt, budget and timeout; a step run enables once per
// step edge; plus a small second instance for saturation and reset length.
module tb_cpu_run_ctrl;

    localparam int RST_CYCLES = 2;
    localparam int TIMEOUT    = 100;
    localparam int LIMIT      = 108;
    localparam int STEP_LEN   = 30;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic        start, step, halt, abort, clear;
    logic [31:0] runCycles;
    logic        coreRst, coreEn, busy, done, timeoutFlag;
    logic [31:0] cycleCount;

    logic        zero = 1'b0;
    logic        sStart, sHalt;
    logic [1:0]  sMode;
    logic [3:0]  sRunCycles;
    logic        sCoreRst, sCoreEn, sBusy, sDone, sTimeout;
    logic [3:0]  sCount;

    int assertCount = 0;
    int failCount   = 0;
    int enCount     = 0;

    bit stepWave [0:63];
    bit haltWave [0:63];

    cpu_run_ctrl #(.CNT_W(32), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .i_mode(mode), .i_start(start), .i_step(step),
        .i_run_cycles(runCycles), .i_halt(halt), .i_abort(abort), .i_clear(clear),
        .o_core_rst(coreRst), .o_core_en(coreEn), .o_cycle_count(cycleCount),
        .o_busy(busy), .o_done(done), .o_timeout(timeoutFlag)
    );

    cpu_run_ctrl #(.CNT_W(4), .RST_CYCLES(3), .TIMEOUT(0)) dutSat (
        .clk(clk), .reset(reset), .i_mode(sMode), .i_start(sStart), .i_step(zero),
        .i_run_cycles(sRunCycles), .i_halt(sHalt), .i_abort(zero), .i_clear(zero),
        .o_core_rst(sCoreRst), .o_core_en(sCoreEn), .o_cycle_count(sCount),
        .o_busy(sBusy), .o_done(sDone), .o_timeout(sTimeout)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Independent tally of enabled cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (coreEn === 1'b1) enCount <= enCount + 1;
    end

    // Hard stop in case the design wedges somewhere unexpected.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then land 1 ns after the next rising edge.
    task automatic applyStimulus(input logic st, input logic [1:0] md, input logic sp,
                                 input logic hl, input logic ab, input logic cl);
        start = st; mode = md; step = sp; halt = hl; abort = ab; clear = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic countResetCycles(output int r);
        r = 0;
        while (coreRst === 1'b1 && r < 20) begin
            r++;
            applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        abort = 1'b0;
    endtask

    task automatic clearAndCheck(input string tag);
        int r;
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput({tag, "_clr_rst"}, 32'(coreRst), 32'd1);
        checkOutput({tag, "_clr_cnt"}, cycleCount, 32'd0);
        checkOutput({tag, "_clr_to"}, 32'(timeoutFlag), 32'd0);
        countResetCycles(r);
        checkOutput({tag, "_rst_len"}, 32'(r), 32'(RST_CYCLES));
        checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic runScenario(input logic [1:0] md, input int n, input int haltAt, input int abortAt);
        int  stopAt;
        int  enStart;
        logic expTo;
        stopAt = 100000;
        expTo  = 1'b0;
        if (abortAt > 0 && abortAt < stopAt) stopAt = abortAt;
        if (haltAt > 0 && haltAt < stopAt) stopAt = haltAt;
        if (md == 2'b10 && n > 0 && n < stopAt) stopAt = n;
        if (TIMEOUT != 0 && TIMEOUT < stopAt) begin
            stopAt = TIMEOUT;
            expTo  = 1'b1;
        end
        if (md == 2'b10 && n == 0) begin
            stopAt = 0;
            expTo  = 1'b0;
        end
        runCycles = (md == 2'b10) ? 32'(n) : $urandom;
        enStart   = enCount;
        applyStimulus(1'b1, md, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("run_busy_c1", 32'(busy), 32'(stopAt > 0));
        checkOutput("run_en_c1", 32'(coreEn), 32'(stopAt > 0));
        for (int c = 1; c <= LIMIT; c++) begin
            applyStimulus(1'b0, md, 1'($urandom_range(0, 1)), 1'(c == haltAt), 1'(c == abortAt),
                          (c < stopAt) ? 1'($urandom_range(0, 7) == 0) : 1'b0);
        end
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("run_done", 32'(done), 32'd1);
        checkOutput("run_busy_end", 32'(busy), 32'd0);
        checkOutput("run_en_end", 32'(coreEn), 32'd0);
        checkOutput("run_count", cycleCount, 32'(stopAt));
        checkOutput("run_timeout", 32'(timeoutFlag), 32'(expTo));
        checkOutput("run_en_cycles", 32'(enCount - enStart), 32'(stopAt));
        clearAndCheck("run");
    endtask

    task automatic stepScenario(input bit directed);
        bit pulse [0:63];
        int stopAt, abortAt, expCount, enStart;
        for (int i = 0; i < 64; i++) begin
            stepWave[i] = 1'b0;
            haltWave[i] = 1'b0;
            pulse[i]    = 1'b0;
        end
        if (directed) begin
            stepWave[2] = 1'b1;
            for (int i = 5; i <= 8; i++) stepWave[i] = 1'b1;
            stepWave[12] = 1'b1;
            haltWave[9]  = 1'b1;
            haltWave[13] = 1'b1;
            abortAt = STEP_LEN;
        end else begin
            for (int i = 1; i <= STEP_LEN; i++) begin
                stepWave[i] = 1'($urandom_range(0, 1));
                haltWave[i] = 1'($urandom_range(0, 9) == 0);
            end
            abortAt = $urandom_range(5, STEP_LEN);
        end
        // Each fresh rising edge yields one enabled cycle right after it.
        stopAt = abortAt;
        for (int c = 1; c <= STEP_LEN; c++) begin
            pulse[c+1] = stepWave[c] && !stepWave[c-1] && !pulse[c];
            if (c < stopAt && pulse[c] && haltWave[c]) stopAt = c;
        end
        expCount = 0;
        for (int c = 1; c <= stopAt; c++) expCount += int'(pulse[c]);
        enStart = enCount;
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("step_busy_c1", 32'(busy), 32'd1);
        for (int c = 1; c <= STEP_LEN + 3; c++) begin
            checkOutput("step_en", 32'(coreEn), 32'(c <= stopAt && pulse[c]));
            applyStimulus(1'b0, 2'b01, stepWave[c], haltWave[c], 1'(c == abortAt), 1'b0);
        end
        checkOutput("step_done", 32'(done), 32'd1);
        checkOutput("step_count", cycleCount, 32'(expCount));
        checkOutput("step_timeout", 32'(timeoutFlag), 32'd0);
        checkOutput("step_en_cycles", 32'(enCount - enStart), 32'(expCount));
        clearAndCheck("step");
    endtask

    task automatic asyncResetCheck(input logic [1:0] md);
        int r;
        int enStart;
        applyStimulus(1'b1, md, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, md, 1'(md == 2'b01), 1'b0, 1'b0, 1'b0);
        checkOutput("ares_en_before", 32'(coreEn), 32'd1);
        step = 1'b0;
        #2 reset = 1'b0;
        #1;
        checkOutput("ares_en", 32'(coreEn), 32'd0);
        checkOutput("ares_rst", 32'(coreRst), 32'd1);
        checkOutput("ares_cnt", cycleCount, 32'd0);
        checkOutput("ares_busy", 32'(busy), 32'd0);
        checkOutput("ares_done", 32'(done), 32'd0);
        enStart = enCount;
        @(posedge clk);
        #1;
        checkOutput("ares_en_held", 32'(coreEn), 32'd0);
        reset = 1'b1;
        countResetCycles(r);
        checkOutput("ares_rst_len", 32'(r), 32'(RST_CYCLES));
        checkOutput("ares_en_cycles", 32'(enCount - enStart), 32'd0);
    endtask

    initial begin
        int r1, r2;
        reset = 1'b0;
        start = 1'b0; mode = 2'b00; step = 1'b0; halt = 1'b0; abort = 1'b0; clear = 1'b0;
        runCycles = 32'd0;
        sStart = 1'b0; sHalt = 1'b0; sMode = 2'b00; sRunCycles = 4'd0;
        $display("[TB] power-on reset");
        repeat (10) @(posedge clk);
        #1;
        checkOutput("por_rst", 32'(coreRst), 32'd1);
        checkOutput("por_en", 32'(coreEn), 32'd0);
        checkOutput("por_cnt", cycleCount, 32'd0);
        checkOutput("por_busy", 32'(busy), 32'd0);
        checkOutput("por_done", 32'(done), 32'd0);
        checkOutput("por_to", 32'(timeoutFlag), 32'd0);
        reset = 1'b1;
        r1 = 0;
        r2 = 0;
        for (int i = 0; i < 8; i++) begin
            r1 += int'(coreRst);
            r2 += int'(sCoreRst);
            applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("por_rst_len", 32'(r1), 32'(RST_CYCLES));
        checkOutput("por_rst_len_sat", 32'(r2), 32'd3);
        checkOutput("por_idle_busy", 32'(busy), 32'd0);

        $display("[TB] saturation on 4-bit instance");
        sStart = 1'b1;
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        sStart = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            sHalt = 1'(c == 20);
            applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        sHalt = 1'b0;
        checkOutput("sat_count", 32'(sCount), 32'd15);
        checkOutput("sat_done", 32'(sDone), 32'd1);
        checkOutput("sat_timeout", 32'(sTimeout), 32'd0);
        checkOutput("sat_en", 32'(sCoreEn), 32'd0);

        $display("[TB] reserved mode and idle abort");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("m11_busy", 32'(busy), 32'd0);
        checkOutput("m11_done", 32'(done), 32'd0);
        checkOutput("m11_rst", 32'(coreRst), 32'd0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("idle_abort_done", 32'(done), 32'd1);
        checkOutput("idle_abort_cnt", cycleCount, 32'd0);
        checkOutput("idle_abort_to", 32'(timeoutFlag), 32'd0);
        clearAndCheck("idle_abort");

        $display("[TB] directed runs");
        runScenario(2'b00, 0, 7, 0);
        runScenario(2'b10, 5, 0, 0);
        runScenario(2'b10, 0, 0, 0);
        runScenario(2'b00, 0, 0, 0);
        runScenario(2'b00, 0, 100, 0);
        runScenario(2'b00, 0, 0, 12);
        runScenario(2'b10, 100, 0, 0);
        runScenario(2'b10, 120, 0, 0);
        runScenario(2'b10, 9, 9, 9);

        $display("[TB] random runs");
        for (int i = 0; i < 12; i++) begin
            runScenario(($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00,
                        $urandom_range(0, 120),
                        ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 120),
                        ($urandom_range(0, 3) == 0) ? $urandom_range(1, 110) : 0);
        end

        $display("[TB] step runs");
        stepScenario(1'b1);
        for (int i = 0; i < 8; i++) stepScenario(1'b0);

        $display("[TB] asynchronous reset mid-operation");
        asyncResetCheck(2'b00);
        asyncResetCheck(2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
